// File: rtl/full_sub_cell.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic a_xor_b;

    // Borrow when a < b, or when a == b and a borrow arrives from below.
    always_comb begin
        a_xor_b = a ^ b;
        d       = a_xor_b ^ bin;
        bout    = (~a & b) | (~a_xor_b & bin);
    end

endmodule

// File: rtl/full_subtractor.sv
// Ripple-borrow subtractor computing a - b - bin over WIDTH bits.
// Diff/borrow are combinational; Diff_q/borrow_q are a registered copy.
module full_subtractor #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] Diff,
    output logic             borrow,
    output logic [WIDTH-1:0] Diff_q,
    output logic             borrow_q
);

    // br[i] is the borrow into bit i; br[0] is the external borrow-in.
    logic [WIDTH:0] br;

    assign br[0]  = bin;
    assign borrow = br[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_sub_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (br[i]),
            .d    (Diff[i]),
            .bout (br[i+1])
        );
    end

    // Output register stage; synchronous reset has priority over load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            Diff_q   <= Diff;
            borrow_q <= borrow;
        end
    end

endmodule

// File: tb/tb_full_subtractor.sv
// Self-checking bench for full_subtractor at WIDTH = 1, 8 and 16.
module tb_full_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // WIDTH = 1 instance
    logic        a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
    logic        diff1, borrow1, diff_q1, borrow_q1;
    // WIDTH = 8 instance
    logic [7:0]  a8 = '0, b8 = '0;
    logic        bin8 = 1'b0;
    logic [7:0]  diff8, diff_q8;
    logic        borrow8, borrow_q8;
    // WIDTH = 16 instance
    logic [15:0] a16 = '0, b16 = '0;
    logic        bin16 = 1'b0;
    logic [15:0] diff16, diff_q16;
    logic        borrow16, borrow_q16;

    full_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .bin(bin1),
        .Diff(diff1), .borrow(borrow1), .Diff_q(diff_q1), .borrow_q(borrow_q1)
    );
    full_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .bin(bin8),
        .Diff(diff8), .borrow(borrow8), .Diff_q(diff_q8), .borrow_q(borrow_q8)
    );
    full_subtractor #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .bin(bin16),
        .Diff(diff16), .borrow(borrow16), .Diff_q(diff_q16), .borrow_q(borrow_q16)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard entry: which instance, and expected {borrow, Diff}.
    typedef struct {
        int          w;
        logic [16:0] exp;
        string       name;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic a, b, bin, d, bo;
    } vec1_t;
    typedef struct {
        logic [7:0] a, b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
    } vec8_t;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%05h, expected 0x%05h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] reg_out(input int w);
        case (w)
            1:       return {borrow_q1, 15'b0, diff_q1};
            8:       return {borrow_q8, 8'b0, diff_q8};
            default: return {borrow_q16, diff_q16};
        endcase
    endfunction

    // Advance one clock edge and check registered outputs against the scoreboard.
    task automatic tick();
        logic rst_at_edge;
        sb_t  e;
        rst_at_edge = rst_n;
        @(posedge clk);
        #1;
        if (!rst_at_edge) begin
            check("reset w1 q", reg_out(1), '0);
            check("reset w8 q", reg_out(8), '0);
            check("reset w16 q", reg_out(16), '0);
            sb_q.delete();
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({e.name, " q"}, reg_out(e.w), e.exp);
        end
    endtask

    task automatic drive1(input string name, input logic a, input logic b, input logic bin,
                          input logic d, input logic bo);
        sb_t e;
        a1 = a; b1 = b; bin1 = bin;
        #1;
        check({name, " comb"}, {borrow1, 15'b0, diff1}, {bo, 15'b0, d});
        e.w = 1; e.exp = {bo, 15'b0, d}; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic drive8(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic bin, input logic [7:0] d, input logic bo);
        sb_t e;
        a8 = a; b8 = b; bin8 = bin;
        #1;
        check({name, " comb"}, {borrow8, 8'b0, diff8}, {bo, 8'b0, d});
        e.w = 8; e.exp = {bo, 8'b0, d}; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic drive16(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic bin);
        sb_t         e;
        logic [16:0] model;
        model = {1'b0, a} - {1'b0, b} - {16'b0, bin};
        a16 = a; b16 = b; bin16 = bin;
        #1;
        check({name, " comb"}, {borrow16, diff16}, model);
        e.w = 16; e.exp = model; e.name = name;
        sb_q.push_back(e);
    endtask

    vec1_t tv1[8];
    vec8_t tv8[4];

    initial begin
        // Truth table: {a,b,bin} -> {Diff,borrow}
        tv1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tv1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tv1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tv1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tv1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tv1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tv1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tv8[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        tv8[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        tv8[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        tv8[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

        // Reset held: combinational path live, registers cleared.
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        #1;
        check("reset comb w1", {borrow1, 15'b0, diff1}, 17'h00001);
        tick();
        tick();
        // Release: data appears one edge later.
        rst_n = 1'b1;
        tick();
        check("reset release q", {borrow_q1, 15'b0, diff_q1}, 17'h00001);

        // WIDTH=1 truth table, one vector per cycle.
        for (int i = 0; i < 8; i++) begin
            drive1($sformatf("w1 tt%0d", i), tv1[i].a, tv1[i].b, tv1[i].bin,
                   tv1[i].d, tv1[i].bo);
            tick();
        end

        // WIDTH=8 directed vectors, including full-chain ripple.
        for (int i = 0; i < 4; i++) begin
            drive8($sformatf("w8 v%0d", i), tv8[i].a, tv8[i].b, tv8[i].bin,
                   tv8[i].d, tv8[i].bo);
            tick();
        end
        // a == b, bin = 0 boundary.
        drive8("w8 equal", 8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0);
        tick();

        // Mid-stream reset: the pending result must be discarded, registers cleared.
        drive8("w8 pre-reset", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive8("w8 post-reset", 8'h10, 8'h20, 1'b1, 8'hEF, 1'b1);
        tick();

        // WIDTH=16 full wrap boundary and random vectors.
        drive16("w16 wrap", 16'h0000, 16'hFFFF, 1'b1);
        tick();
        for (int i = 0; i < 1000; i++) begin
            drive16($sformatf("w16 rnd%0d", i), 16'($urandom), 16'($urandom),
                    1'($urandom_range(1, 0)));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
